// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch history table predictor.
//   BP_SNT/BP_WNT/BP_WT/BP_ST : 2-bit saturating counter states
//   bp_sat_update(cnt, taken) : next counter value after a resolved branch
package bp_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  // Move one step toward the resolved direction, holding at either extreme.
  function automatic logic [1:0] bp_sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BP_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BP_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_stat.sv
// bp_sat_stat: CNT_W-bit event counter that sticks at all-ones instead of wrapping.
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset, clears count
//   inc   in  count one event this cycle
//   count out current event total
module bp_sat_stat #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Once every bit is set the counter holds, so long runs read as "at least max".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: PC-indexed table of 2-bit saturating counters.
//   Optional macro BP_GSHARE_EN: XOR a global history register into the index.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   pc_if             fetch PC; prediction is combinational from it
//   prediction        predicted direction for pc_if (1 = taken)
//   branchex          a branch resolves in EX this cycle
//   pc_ex, outcome    PC and actual direction of the resolving branch
//   pred_ex           prediction that was made for that branch at fetch
//   mispredict        branchex & (outcome != pred_ex)
//   branch_count      saturating count of resolved branches
//   mispredict_count  saturating count of mispredicted branches
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int IDX_BITS  = 4,
  parameter int HIST_BITS = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pc_if,
  output logic             prediction,
  input  logic             branchex,
  input  logic [PC_W-1:0]  pc_ex,
  input  logic             outcome,
  input  logic             pred_ex,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // The history is zero-extended into the index, so it cannot be wider than it.
  if (HIST_BITS > IDX_BITS) begin : g_bad_hist
    $error("HIST_BITS must not exceed IDX_BITS");
  end

  logic [1:0]          bht [ENTRIES];
  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] ghr;
  logic [IDX_BITS-1:0]  hist_ext;

  assign hist_ext = IDX_BITS'(ghr);
  assign rd_idx   = pc_if[IDX_BITS+1:2] ^ hist_ext;
  // Update indexes with the history as it stood before this branch shifts in.
  assign wr_idx   = pc_ex[IDX_BITS+1:2] ^ hist_ext;

  // Newest outcome enters at bit 0; the oldest falls off the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (branchex) begin
      ghr <= HIST_BITS'({ghr, outcome});
    end
  end
`else
  assign rd_idx = pc_if[IDX_BITS+1:2];
  assign wr_idx = pc_ex[IDX_BITS+1:2];
`endif

  // Byte-offset and high PC bits never reach the index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if[PC_W-1:IDX_BITS+2], pc_if[1:0],
                            pc_ex[PC_W-1:IDX_BITS+2], pc_ex[1:0]};

  // Read straight from the flops: a same-cycle update to the same entry is not
  // bypassed, fetch sees the value from before the edge.
  assign prediction = bht[rd_idx][1];

  assign mispredict = branchex & (outcome != pred_ex);

  // Every entry starts weakly not-taken so one taken branch flips it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= BP_WNT;
      end
    end else if (branchex) begin
      bht[wr_idx] <= bp_sat_update(bht[wr_idx], outcome);
    end
  end

  bp_sat_stat #(.CNT_W(CNT_W)) u_branch_stat (
    .clk   (clk),
    .rst   (rst),
    .inc   (branchex),
    .count (branch_count)
  );

  bp_sat_stat #(.CNT_W(CNT_W)) u_mispredict_stat (
    .clk   (clk),
    .rst   (rst),
    .inc   (mispredict),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: self-checking bench for branch_predictor_bht.
//   Built with IDX_BITS=4, HIST_BITS=2, CNT_W=4 so saturation is reachable.
//   The gshare scenario only runs when BP_GSHARE_EN is defined.
module tb_branch_predictor_bht;

  localparam int PC_W      = 32;
  localparam int IDX_BITS  = 4;
  localparam int HIST_BITS = 2;
  localparam int CNT_W     = 4;

  logic             clk;
  logic             rst;
  logic [PC_W-1:0]  pc_if;
  logic             prediction;
  logic             branchex;
  logic [PC_W-1:0]  pc_ex;
  logic             outcome;
  logic             pred_ex;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]      pc;
    logic             pred;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0]           mdl_tbl [16];
  logic [HIST_BITS-1:0] mdl_ghr;
  logic [CNT_W-1:0]     mdl_bc;
  logic [CNT_W-1:0]     mdl_mc;

  branch_predictor_bht #(
    .PC_W(PC_W), .IDX_BITS(IDX_BITS), .HIST_BITS(HIST_BITS), .CNT_W(CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_if            (pc_if),
    .prediction       (prediction),
    .branchex         (branchex),
    .pc_ex            (pc_ex),
    .outcome          (outcome),
    .pred_ex          (pred_ex),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int midx(input logic [31:0] pc);
    int i;
    i = int'(pc[5:2]);
`ifdef BP_GSHARE_EN
    i = i ^ int'(mdl_ghr);
`endif
    return i;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == 4'd15) ? c : c + 4'd1;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_tbl[i] = 2'b01;
    mdl_ghr = '0;
    mdl_bc  = '0;
    mdl_mc  = '0;
  endtask

  task automatic mdl_update(input logic [31:0] pc, input logic tk, input logic pe);
    int i;
    i = midx(pc);
    case (mdl_tbl[i])
      2'b00: mdl_tbl[i] = tk ? 2'b01 : 2'b00;
      2'b01: mdl_tbl[i] = tk ? 2'b10 : 2'b00;
      2'b10: mdl_tbl[i] = tk ? 2'b11 : 2'b01;
      default: mdl_tbl[i] = tk ? 2'b11 : 2'b10;
    endcase
    mdl_bc = sat_inc(mdl_bc);
    if (tk != pe) mdl_mc = sat_inc(mdl_mc);
    mdl_ghr = HIST_BITS'({mdl_ghr, tk});
  endtask

  function automatic logic mdl_pred(input logic [31:0] pc);
    logic [1:0] e;
    e = mdl_tbl[midx(pc)];
    return e[1];
  endfunction

  // Pop every pending expectation and compare against the DUT outputs.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      pc_if = e.pc;
      #1;
      checks++;
      if (prediction !== e.pred) begin
        errors++;
        $display("[TB] FAIL pred pc=%h got %b need %b", e.pc, prediction, e.pred);
      end
      checks++;
      if (branch_count !== e.bc) begin
        errors++;
        $display("[TB] FAIL branch_count got %0d need %0d", branch_count, e.bc);
      end
      checks++;
      if (mispredict_count !== e.mc) begin
        errors++;
        $display("[TB] FAIL mispredict_count got %0d need %0d", mispredict_count, e.mc);
      end
    end
  endtask

  // One resolving branch; branchex stays high afterwards so calls can chain back to back.
  task automatic do_update(input logic [31:0] pc, input logic tk, input logic pe,
                           input logic [31:0] probe);
    exp_t e;
    @(negedge clk);
    branchex = 1'b1;
    pc_ex    = pc;
    outcome  = tk;
    pred_ex  = pe;
    #1;
    checks++;
    if (mispredict !== (tk != pe)) begin
      errors++;
      $display("[TB] FAIL mispredict pc=%h got %b need %b", pc, mispredict, tk != pe);
    end
    @(posedge clk);
    mdl_update(pc, tk, pe);
    e.pc = probe;
    e.pred = mdl_pred(probe);
    e.bc = mdl_bc;
    e.mc = mdl_mc;
    sb.push_back(e);
    #1;
    drain();
  endtask

  task automatic go_idle();
    @(negedge clk);
    branchex = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    branchex = 1'b0;
    rst = 1'b1;
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    pc_if = 32'h40;
    #1;
    checks++;
    if (prediction !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred got %b need 0", prediction); end
    checks++;
    if (branch_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_bc got %0d need 0", branch_count); end
    checks++;
    if (mispredict_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_mc got %0d need 0", mispredict_count); end
    checks++;
    if (mispredict !== 1'b0) begin errors++; $display("[TB] FAIL reset_mispredict got %b need 0", mispredict); end
    // All entries must read weakly not-taken
    for (int i = 0; i < 16; i++) begin
      pc_if = 32'(i) << 2;
      #1;
      checks++;
      if (prediction !== 1'b0) begin errors++; $display("[TB] FAIL reset_entry%0d got %b need 0", i, prediction); end
    end
  endtask

  task automatic test_train_taken();
    do_reset();
    do_update(32'h40, 1'b1, 1'b0, 32'h40);
    do_update(32'h40, 1'b1, 1'b0, 32'h40);
    go_idle();
    pc_if = 32'h40;
    #1;
    checks++;
    if (prediction !== 1'b1 || branch_count !== 4'd2 || mispredict_count !== 4'd2) begin
      errors++;
      $display("[TB] FAIL train_taken got pred=%b bc=%0d mc=%0d need 1/2/2",
               prediction, branch_count, mispredict_count);
    end
  endtask

  task automatic test_decrement();
    logic [3:0] want;
    want = 4'b0001;
    do_reset();
    do_update(32'h48, 1'b1, 1'b0, 32'h48);
    do_update(32'h48, 1'b1, 1'b1, 32'h48);
    // Strong taken now; four not-taken steps read 1,0,0,0 afterwards
    for (int k = 0; k < 4; k++) begin
      do_update(32'h48, 1'b0, mdl_pred(32'h48), 32'h48);
      checks++;
      if (prediction !== (k == 0)) begin
        errors++;
        $display("[TB] FAIL decrement_step%0d got %b need %b", k, prediction, k == 0);
      end
    end
    go_idle();
  endtask

  task automatic test_alias_and_no_bypass();
    do_reset();
    do_update(32'h04, 1'b1, 1'b0, 32'h44);
    // Same-cycle read of the entry being updated returns the old value
    @(negedge clk);
    branchex = 1'b1;
    pc_ex    = 32'h44;
    outcome  = 1'b0;
    pred_ex  = 1'b1;
    pc_if    = 32'h04;
    #1;
    checks++;
    if (prediction !== mdl_pred(32'h04)) begin
      errors++;
      $display("[TB] FAIL no_bypass got %b need %b", prediction, mdl_pred(32'h04));
    end
    @(posedge clk);
    mdl_update(32'h44, 1'b0, 1'b1);
    #1;
    checks++;
    if (prediction !== mdl_pred(32'h04)) begin
      errors++;
      $display("[TB] FAIL alias_after got %b need %b", prediction, mdl_pred(32'h04));
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_update(32'h10, 1'b1, 1'b0, 32'h10);
    do_update(32'h10, 1'b1, 1'b1, 32'h10);
    do_update(32'h10, 1'b0, 1'b1, 32'h10);
    go_idle();
    pc_if = 32'h10;
    #1;
    checks++;
    if (prediction !== mdl_pred(32'h10)) begin
      errors++;
      $display("[TB] FAIL back_to_back got %b need %b", prediction, mdl_pred(32'h10));
    end
  endtask

  task automatic test_saturation();
    logic tk;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tk = k[0];
      do_update(32'h20 + 32'(k % 4) * 4, tk, ~tk, 32'h20);
    end
    go_idle();
    #1;
    checks++;
    if (branch_count !== 4'd15 || mispredict_count !== 4'd15) begin
      errors++;
      $display("[TB] FAIL saturation got bc=%0d mc=%0d need 15/15", branch_count, mispredict_count);
    end
  endtask

  task automatic test_x_idle();
    @(negedge clk);
    branchex = 1'b0;
    pc_ex    = 'x;
    outcome  = 1'bx;
    pred_ex  = 1'bz;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mispredict !== 1'b0 || branch_count !== mdl_bc || mispredict_count !== mdl_mc) begin
      errors++;
      $display("[TB] FAIL x_idle got mp=%b bc=%0d mc=%0d need 0/%0d/%0d",
               mispredict, branch_count, mispredict_count, mdl_bc, mdl_mc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_update(32'h40, 1'b1, 1'b0, 32'h40);
    do_update(32'h40, 1'b1, 1'b0, 32'h40);
    @(negedge clk);
    branchex = 1'b1;
    pc_ex    = 32'h40;
    outcome  = 1'b1;
    pred_ex  = 1'b0;
    #2;
    rst = 1'b1;
    mdl_reset();
    @(posedge clk);
    #1;
    pc_if = 32'h40;
    #1;
    checks++;
    if (prediction !== 1'b0 || branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid got pred=%b bc=%0d mc=%0d need 0/0/0",
               prediction, branch_count, mispredict_count);
    end
    @(negedge clk);
    branchex = 1'b0;
    rst = 1'b0;
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare();
    do_reset();
    do_update(32'h20, 1'b1, 1'b0, 32'h20);
    do_update(32'h24, 1'b1, 1'b0, 32'h24);
    // History is now 11, so pc 0x00 trains index 3
    do_update(32'h00, 1'b1, 1'b0, 32'h00);
    go_idle();
    pc_if = 32'h00;
    #1;
    checks++;
    if (prediction !== 1'b1) begin errors++; $display("[TB] FAIL gshare_trained got %b need 1", prediction); end
    do_reset();
    pc_if = 32'h0C;
    #1;
    checks++;
    if (prediction !== 1'b0) begin errors++; $display("[TB] FAIL gshare_reset got %b need 0", prediction); end
    // With history back at 0 a single taken at 0x00 trains index 0 only
    do_update(32'h00, 1'b1, 1'b0, 32'h04);
    go_idle();
  endtask
`endif

  initial begin
    rst      = 1'b1;
    branchex = 1'b0;
    pc_if    = '0;
    pc_ex    = '0;
    outcome  = 1'b0;
    pred_ex  = 1'b0;
    mdl_reset();
    test_reset();
    test_train_taken();
    test_decrement();
    test_alias_and_no_bypass();
    test_back_to_back();
    test_x_idle();
    test_saturation();
    test_reset_mid();
`ifdef BP_GSHARE_EN
    test_gshare();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised, PC-indexed branch history table (BHT) of 2-bit saturating counters. It replaces the fixed 3-bit single-entry predictor. The fetch stage reads a taken/not-taken prediction for the current PC in the same cycle. The EX stage writes back the resolved outcome of each branch and reports whether that branch was mispredicted. The block also keeps saturating branch and mispredict statistics for performance measurement.

## Interface
- `PC_W`, 32, PC width in bits
- `IDX_BITS`, 4, table index width; the table has 2^IDX_BITS entries
- `HIST_BITS`, 4, global history length; only used with `BP_GSHARE_EN`; must be ≤ `IDX_BITS`
- `CNT_W`, 32, width of each statistics counter

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc_if`  in  PC_W  PC of the instruction in fetch
- `prediction`  out  1  predicted direction for `pc_if`; 1 = taken
- `branchex`  in  1  a branch is resolving in EX this cycle
- `pc_ex`  in  PC_W  PC of the resolving branch
- `outcome`  in  1  actual branch direction; 1 = taken
- `pred_ex`  in  1  prediction made for this branch at fetch, piped to EX
- `mispredict`  out  1  `branchex & (outcome != pred_ex)`
- `branch_count`  out  CNT_W  number of resolved branches
- `mispredict_count`  out  CNT_W  number of mispredicted branches

## Operation
- Storage: 2^IDX_BITS counters, 2 bits each.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Index: `idx(pc) = pc[IDX_BITS+1:2]` (word-aligned PC).
- Read: `prediction = table[idx(pc_if)][1]`. This is combinational; no enable is needed.
- Update, on a `clk` edge when `branchex=1`:
  - `table[idx(pc_ex)]` increments if `outcome=1`, saturating at 11.
  - It decrements if `outcome=0`, saturating at 00.
- Statistics, on a `clk` edge when `branchex=1`:
  - `branch_count` increments.
  - If `mispredict=1`, `mispredict_count` also increments.
  - Both counters saturate at all-ones and never wrap.
- `mispredict` is combinational and is 0 whenever `branchex=0`.
- Same-cycle read and update to the same index: `prediction` returns the pre-update value. There is no bypass.
- Reset state:
  - Every table entry = 01.
  - Statistics counters = 0.
  - Global history = 0.
  - `prediction` = 0 after reset.
  - `mispredict` = 0 while `branchex=0`.
- Reset asserted mid-operation clears all state immediately, whether or not an update is pending. The block ignores `branchex` while `rst=1`.
- Inputs containing X/Z while `branchex=0` have no effect on state.

## Timing
- Prediction latency: 0 cycles, combinational from `pc_if`.
- Update latency: 1 cycle. A new counter value is visible on `prediction` in the cycle after the `branchex` edge.
- Statistics are visible in the cycle after the update edge.
- One update per cycle at most. Back-to-back `branchex` cycles to the same index each apply in sequence: two taken updates take 01 to 11.
- No handshake. The EX stage guarantees that `pc_ex`, `outcome` and `pred_ex` are valid whenever `branchex=1`.

## Configuration
- `BP_GSHARE_EN` defined: gshare indexing.
  - Global history register `ghr[HIST_BITS-1:0]` shifts left, inserting `outcome` at bit 0 on every `branchex` edge.
  - Both read and update index become `idx(pc) ^ {{(IDX_BITS-HIST_BITS){1'b0}}, ghr}`.
  - Update uses the history value before the shift.
  - `ghr` resets to 0.
- `BP_GSHARE_EN` undefined: pure PC indexing. No history register is instantiated and `HIST_BITS` is unused.

## Structure
- Package `bp_pkg` holds:
  - localparams `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`;
  - function `bp_sat_update(cnt, taken)` returning the next 2-bit counter value.
- Sub-module `bp_sat_stat`: a `CNT_W` saturating event counter with `clk`, `rst`, `inc`, `count`. It is instantiated twice, once for branches and once for mispredicts.
- Table is implemented in flops; no RAM macro.

## Test plan
- Reset, then `pc_if=0x40` → `prediction=0`, both counts 0, `mispredict=0`.
- Two taken updates at `pc_ex=0x40` with `pred_ex=0` → after the second edge, `prediction=1` for `pc_if=0x40`; `branch_count=2`, `mispredict_count=2`.
- Three not-taken updates on a strong-taken entry → counter steps 11, 10, 01, 00; `prediction` changes from 1 to 0 after the second update; a fourth update keeps the entry at 00.
- Aliasing: `pc_ex=0x04` and `0x44` with `IDX_BITS=4` share index 1; an update via one PC is visible through the other. `pc_if` equal to `pc_ex` in the update cycle → old prediction returned.
- Statistics saturation: with `CNT_W=4`, 20 mispredicted branches → both counts held at 15, no wrap.
- With `BP_GSHARE_EN`, `HIST_BITS=2`:
  - Outcomes T, T → `ghr=11`.
  - A taken update at `pc_ex=0x00` then trains index 3.
  - Result: `pc_if=0x00` predicts 1; `pc_if=0x0C` after a reset-history run predicts 0.
  - Asserting `rst` mid-sequence → `ghr=0` and all entries back to 01.
